udp_header_parser: RTL and testbench
====================================

UDP_HEADER_PARSER -- requirements
Module: udp_header_parser

Interface
REQ-001 SHALL have parameter FILTER_EN, default 0, meaning 1 enables destination-port filtering.
REQ-002 SHALL have parameter FILTER_PORT, default 16'd4791, meaning the accepted destination port when FILTER_EN=1.
REQ-003 SHALL have port clk  in  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rstn  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port s_data  in  8  input UDP datagram byte stream, header first, MSB-first.
REQ-006 SHALL have ports s_valid in 1, s_ready out 1 and s_last in 1, meaning input handshake and last byte of datagram.
REQ-007 SHALL have ports src_port, dst_port, udp_length and udp_checksum, each out 16, meaning the parsed header fields.
REQ-008 SHALL have port hdr_valid  out  1  one-cycle pulse; header fields are valid.
REQ-009 SHALL have ports m_data out 8, m_valid out 1, m_ready in 1 and m_last out 1, meaning the payload output stream.
REQ-010 SHALL have ports err_short, err_length and port_drop, each out 1, each a one-cycle error or event pulse.
REQ-011 SHALL have ports stat_pkt_cnt and stat_err_cnt, each out 16, meaning good-header count and error count.

Function
REQ-012 SHALL implement states HDR, PAYLOAD and DROP; reset state is HDR.
REQ-013 In HDR: s_ready=1, m_valid=0; a 3-bit byte counter counts accepted bytes 0..7.
REQ-014 Header bytes SHALL map as follows: 0-1 src_port, 2-3 dst_port, 4-5 udp_length, 6-7 udp_checksum, high byte first.
REQ-015 Field outputs SHALL update only on acceptance of byte 7 and hold until the next byte 7.
REQ-016 hdr_valid SHALL pulse in the cycle after byte 7 is accepted; latency is 1 cycle.
REQ-017 s_last on header bytes 0-6 SHALL pulse err_short, reset the counter and stay in HDR, with no hdr_valid.
REQ-018 On byte 7 with udp_length<8: pulse err_length; go to HDR if s_last on byte 7, else DROP.
REQ-019 On byte 7 with udp_length==8: zero-payload datagram; go to HDR if s_last, else DROP without error (trailing pad).
REQ-020 On byte 7 with FILTER_EN=1 and dst_port!=FILTER_PORT: pulse port_drop; hdr_valid still pulses; go to DROP, or HDR if s_last.
REQ-021 Otherwise byte 7 without s_last SHALL go to PAYLOAD with a 16-bit remaining counter = udp_length-8.
REQ-022 byte 7 with s_last when udp_length>8 SHALL pulse err_length and go to HDR.
REQ-023 PAYLOAD SHALL be combinational pass-through: m_data=s_data, m_valid=s_valid, s_ready=m_ready.
REQ-024 In PAYLOAD, remaining SHALL decrement per accepted byte; m_last=1 when remaining==1 or s_last.
REQ-025 remaining==1 accepted without s_last SHALL go to DROP without error (Ethernet padding).
REQ-026 s_last accepted with remaining>1 SHALL pulse err_length, forward m_last=1 and go to HDR.
REQ-027 remaining==1 together with s_last SHALL give a normal end and go to HDR.
REQ-028 DROP SHALL drive s_ready=1 and m_valid=0, and return to HDR after s_last is accepted.
REQ-029 stat_pkt_cnt SHALL increment on every hdr_valid and wrap FFFF->0000.
REQ-030 stat_err_cnt SHALL increment on any err_short or err_length pulse and saturate at FFFF.
REQ-031 At most one of err_short and err_length SHALL pulse per cycle; port_drop is independent of both.

Reset
REQ-032 rstn low SHALL immediately force HDR, all counters 0, and all outputs 0 except s_ready=1, regardless of mid-datagram state.
REQ-033 After reset release, the first accepted byte SHALL be treated as header byte 0.

Verification
REQ-034 Header 04 D2 12 B7 00 0C AB CD + payload 11 22 33 44 with last on 44 -> fields 0x04D2/0x12B7/0x000C/0xABCD, hdr_valid once, m_last on 44, stat_pkt_cnt=1.
REQ-035 Same frame with m_ready low 3 cycles mid-payload -> s_ready low for those cycles, no byte lost or duplicated.
REQ-036 Length 0x000A with 6 payload bytes -> 2 payload bytes out, m_last on 2nd, 4 bytes dropped, no error.
REQ-037 s_last on header byte 4 -> err_short pulse, no hdr_valid; next frame parses correctly.
REQ-038 FILTER_EN=1 with dst 0x0035 -> port_drop, m_valid stays 0; length 0x0004 -> err_length; stat_err_cnt preset to FFFF holds FFFF.
REQ-039 rstn low during payload byte 2 -> HDR, counters 0; next frame parses from byte 0.

Source files
------------

// File: rtl/udp_header_parser.sv
// udp_header_parser
//   Splits a byte-serial UDP datagram into its 8-byte header fields and a
//   payload stream. Bytes arrive MSB-first on a valid/ready handshake.
//
//   Parameters
//     FILTER_EN    non-zero: datagrams whose destination port differs from
//                  FILTER_PORT are flagged with port_drop and discarded
//     FILTER_PORT  accepted destination port when filtering is enabled
//
//   Ports
//     clk, rstn                 clock (rising edge), async active-low reset
//     s_data/s_valid/s_ready/s_last   input datagram byte stream
//     src_port, dst_port, udp_length, udp_checksum   parsed header fields
//     hdr_valid                 one-cycle pulse, fields freshly updated
//     m_data/m_valid/m_ready/m_last   payload byte stream
//     err_short, err_length, port_drop  one-cycle event pulses
//     stat_pkt_cnt              headers reported (wraps)
//     stat_err_cnt              short/length errors (saturates)
module udp_header_parser #(
  parameter int unsigned FILTER_EN   = 0,
  parameter logic [15:0] FILTER_PORT = 16'd4791
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        s_last,
  output logic [15:0] src_port,
  output logic [15:0] dst_port,
  output logic [15:0] udp_length,
  output logic [15:0] udp_checksum,
  output logic        hdr_valid,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        err_short,
  output logic        err_length,
  output logic        port_drop,
  output logic [15:0] stat_pkt_cnt,
  output logic [15:0] stat_err_cnt
);

  typedef enum logic [1:0] {
    HDR,
    PAYLOAD,
    DROP
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [55:0] hbuf_q, hbuf_d;
  logic [15:0] src_q, src_d;
  logic [15:0] dst_q, dst_d;
  logic [15:0] len_q, len_d;
  logic [15:0] csum_q, csum_d;
  logic [15:0] rem_q, rem_d;
  logic        hdr_valid_q, hdr_valid_d;
  logic        err_short_q, err_short_d;
  logic        err_length_q, err_length_d;
  logic        port_drop_q, port_drop_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  logic        acc;
  logic [63:0] hdr_full;
  logic [15:0] f_dst;
  logic [15:0] f_len;
  logic        len_bad;
  logic        len_err;
  logic        filter_miss;

  // Stream-side outputs depend only on registered state and live inputs,
  // which keeps the handshake free of combinational loops.
  always_comb begin
    s_ready = 1'b1;
    m_valid = 1'b0;
    m_data  = '0;
    m_last  = 1'b0;
    if (state_q == PAYLOAD) begin
      s_ready = m_ready;
      m_valid = s_valid;
      m_data  = s_data;
      m_last  = (rem_q == 16'd1) || s_last;
    end
  end

  assign acc = s_valid && s_ready;

  // Byte 7 completes the header together with the seven buffered bytes.
  assign hdr_full    = {hbuf_q, s_data};
  assign f_dst       = hdr_full[47:32];
  assign f_len       = hdr_full[31:16];
  assign len_bad     = (f_len < 16'd8);
  assign len_err     = len_bad || (s_last && (f_len > 16'd8));
  assign filter_miss = (FILTER_EN != 0) && (f_dst != FILTER_PORT);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hbuf_d       = hbuf_q;
    src_d        = src_q;
    dst_d        = dst_q;
    len_d        = len_q;
    csum_d       = csum_q;
    rem_d        = rem_q;
    hdr_valid_d  = 1'b0;
    err_short_d  = 1'b0;
    err_length_d = 1'b0;
    port_drop_d  = 1'b0;

    unique case (state_q)
      HDR: begin
        if (acc) begin
          if (cnt_q != 3'd7) begin
            hbuf_d = {hbuf_q[47:0], s_data};
            if (s_last) begin
              err_short_d = 1'b1;
              cnt_d       = '0;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end else begin
            cnt_d        = '0;
            src_d        = hdr_full[63:48];
            dst_d        = f_dst;
            len_d        = f_len;
            csum_d       = hdr_full[15:0];
            err_length_d = len_err;
            port_drop_d  = filter_miss;
            // A filtered header is still reported; a malformed length is not.
            hdr_valid_d  = !len_err;
            if (!s_last) begin
              if (len_bad || (f_len == 16'd8) || filter_miss) begin
                state_d = DROP;
              end else begin
                state_d = PAYLOAD;
                rem_d   = f_len - 16'd8;
              end
            end
          end
        end
      end
      PAYLOAD: begin
        if (acc) begin
          rem_d = rem_q - 16'd1;
          if (s_last) begin
            err_length_d = (rem_q != 16'd1);
            state_d      = HDR;
          end else if (rem_q == 16'd1) begin
            // Trailing bytes beyond udp_length are link-layer padding.
            state_d = DROP;
          end
        end
      end
      DROP: begin
        if (acc && s_last) begin
          state_d = HDR;
        end
      end
      default: state_d = HDR;
    endcase
  end

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    err_cnt_d = err_cnt_q;
    if (hdr_valid_d) begin
      pkt_cnt_d = pkt_cnt_q + 16'd1;
    end
    if ((err_short_d || err_length_d) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= HDR;
      cnt_q        <= '0;
      hbuf_q       <= '0;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      csum_q       <= '0;
      rem_q        <= '0;
      hdr_valid_q  <= 1'b0;
      err_short_q  <= 1'b0;
      err_length_q <= 1'b0;
      port_drop_q  <= 1'b0;
      pkt_cnt_q    <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hbuf_q       <= hbuf_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      csum_q       <= csum_d;
      rem_q        <= rem_d;
      hdr_valid_q  <= hdr_valid_d;
      err_short_q  <= err_short_d;
      err_length_q <= err_length_d;
      port_drop_q  <= port_drop_d;
      pkt_cnt_q    <= pkt_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign src_port     = src_q;
  assign dst_port     = dst_q;
  assign udp_length   = len_q;
  assign udp_checksum = csum_q;
  assign hdr_valid    = hdr_valid_q;
  assign err_short    = err_short_q;
  assign err_length   = err_length_q;
  assign port_drop    = port_drop_q;
  assign stat_pkt_cnt = pkt_cnt_q;
  assign stat_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_udp_header_parser.sv
// Directed bench for udp_header_parser, built with destination filtering
// enabled and the accepted port set to 0x12B7.
module tb_udp_header_parser;

  logic        clk;
  logic        rstn;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        s_last;
  logic [15:0] src_port, dst_port, udp_length, udp_checksum;
  logic        hdr_valid;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        err_short, err_length, port_drop;
  logic [15:0] stat_pkt_cnt, stat_err_cnt;

  int unsigned vectors = 0;
  int unsigned fails   = 0;

  int unsigned hv_cnt, es_cnt, el_cnt, pd_cnt, mv_cnt;
  logic [8:0]  out_q[$];

  udp_header_parser #(
    .FILTER_EN  (1),
    .FILTER_PORT(16'h12B7)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_last      (s_last),
    .src_port    (src_port),
    .dst_port    (dst_port),
    .udp_length  (udp_length),
    .udp_checksum(udp_checksum),
    .hdr_valid   (hdr_valid),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_last      (m_last),
    .err_short   (err_short),
    .err_length  (err_length),
    .port_drop   (port_drop),
    .stat_pkt_cnt(stat_pkt_cnt),
    .stat_err_cnt(stat_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 ns after the rising edge; outputs are observed here.
  always @(negedge clk) begin
    if (rstn) begin
      if (m_valid && m_ready) out_q.push_back({m_last, m_data});
      if (m_valid)    mv_cnt++;
      if (hdr_valid)  hv_cnt++;
      if (err_short)  es_cnt++;
      if (err_length) el_cnt++;
      if (port_drop)  pd_cnt++;
    end
  end

  task automatic clr();
    hv_cnt = 0; es_cnt = 0; el_cnt = 0; pd_cnt = 0; mv_cnt = 0;
    out_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put_byte(input logic [7:0] b, input logic l);
    int unsigned n;
    n = 0;
    s_data = b; s_valid = 1'b1; s_last = l;
    @(negedge clk);
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      vectors++; fails++;
      $display("FAIL put_byte_timeout got s_ready=%b want 1", s_ready);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  // Bytes are left-justified in v; s_last on the final byte if l_end.
  task automatic send_frame(input logic [127:0] v, input int n, input logic l_end);
    for (int i = 0; i < n; i++)
      put_byte(v[127-8*i -: 8], l_end && (i == n - 1));
  endtask

  task automatic test_reset();
    rstn = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b1;
    #12;
    vectors++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || hdr_valid !== 1'b0 || m_last !== 1'b0) begin
      fails++;
      $display("FAIL reset_hs got s_ready=%b m_valid=%b hdr_valid=%b m_last=%b want 1 0 0 0",
               s_ready, m_valid, hdr_valid, m_last);
    end
    vectors++;
    if ({src_port, dst_port, udp_length, udp_checksum, stat_pkt_cnt, stat_err_cnt} !== 96'h0 ||
        {err_short, err_length, port_drop} !== 3'b000) begin
      fails++;
      $display("FAIL reset_regs got src=%h dst=%h len=%h cs=%h pkt=%h err=%h want all 0",
               src_port, dst_port, udp_length, udp_checksum, stat_pkt_cnt, stat_err_cnt);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    idle(1);
    clr();
  endtask

  task automatic test_basic(input logic [15:0] exp_pkt);
    clr();
    send_frame({64'h04D212B7000CABCD, 64'h0}, 8, 1'b0);
    vectors++;
    if (hdr_valid !== 1'b1) begin
      fails++; $display("FAIL hdr_latency got hdr_valid=%b want 1", hdr_valid);
    end
    send_frame({32'h11223344, 96'h0}, 4, 1'b1);
    idle(2);
    vectors++;
    if ({src_port, dst_port, udp_length, udp_checksum} !== 64'h04D212B7000CABCD) begin
      fails++;
      $display("FAIL basic_fields got %h %h %h %h want 04d2 12b7 000c abcd",
               src_port, dst_port, udp_length, udp_checksum);
    end
    vectors++;
    if (hv_cnt != 1 || es_cnt != 0 || el_cnt != 0 || pd_cnt != 0) begin
      fails++;
      $display("FAIL basic_pulses got hv=%0d es=%0d el=%0d pd=%0d want 1 0 0 0",
               hv_cnt, es_cnt, el_cnt, pd_cnt);
    end
    vectors++;
    if (out_q.size() != 4 || out_q[0] !== 9'h011 || out_q[1] !== 9'h022 ||
        out_q[2] !== 9'h033 || out_q[3] !== 9'h144) begin
      fails++; $display("FAIL basic_payload got %p want 011 022 033 144", out_q);
    end
    vectors++;
    if (stat_pkt_cnt !== exp_pkt) begin
      fails++; $display("FAIL basic_pkt_cnt got %h want %h", stat_pkt_cnt, exp_pkt);
    end
  endtask

  task automatic test_stall();
    int unsigned lowcnt;
    clr();
    send_frame({80'h04D212B7000CABCD1122, 48'h0}, 10, 1'b0);
    s_data = 8'h33; s_valid = 1'b1; m_ready = 1'b0;
    lowcnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (s_ready === 1'b0 && m_valid === 1'b1) lowcnt++;
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    vectors++;
    if (lowcnt != 3) begin
      fails++; $display("FAIL stall_ready got %0d stalled cycles want 3", lowcnt);
    end
    put_byte(8'h33, 1'b0);
    put_byte(8'h44, 1'b1);
    idle(2);
    vectors++;
    if (out_q.size() != 4 || out_q[0] !== 9'h011 || out_q[1] !== 9'h022 ||
        out_q[2] !== 9'h033 || out_q[3] !== 9'h144) begin
      fails++; $display("FAIL stall_payload got %p want 011 022 033 144", out_q);
    end
    vectors++;
    if (stat_pkt_cnt !== 16'd2 || hv_cnt != 1) begin
      fails++; $display("FAIL stall_pkt got pkt=%h hv=%0d want 0002 1", stat_pkt_cnt, hv_cnt);
    end
  endtask

  task automatic test_pad();
    clr();
    send_frame({64'h000112B7000A0000, 48'hAABBCCDDEEFF, 16'h0}, 14, 1'b1);
    idle(2);
    vectors++;
    if (out_q.size() != 2 || out_q[0] !== 9'h0AA || out_q[1] !== 9'h1BB) begin
      fails++; $display("FAIL pad_payload got %p want 0aa 1bb", out_q);
    end
    vectors++;
    if (es_cnt != 0 || el_cnt != 0 || stat_err_cnt !== 16'd0 || stat_pkt_cnt !== 16'd3) begin
      fails++;
      $display("FAIL pad_status got es=%0d el=%0d err=%h pkt=%h want 0 0 0000 0003",
               es_cnt, el_cnt, stat_err_cnt, stat_pkt_cnt);
    end
  endtask

  task automatic test_short();
    clr();
    send_frame({40'h0102030405, 88'h0}, 5, 1'b1);
    idle(2);
    vectors++;
    if (es_cnt != 1 || hv_cnt != 0 || el_cnt != 0 || stat_err_cnt !== 16'd1) begin
      fails++;
      $display("FAIL short_err got es=%0d hv=%0d el=%0d err=%h want 1 0 0 0001",
               es_cnt, hv_cnt, el_cnt, stat_err_cnt);
    end
    vectors++;
    if (src_port !== 16'h0001 || udp_length !== 16'h000A) begin
      fails++; $display("FAIL short_hold got src=%h len=%h want 0001 000a", src_port, udp_length);
    end
    test_basic(16'd4);
  endtask

  task automatic test_filter();
    clr();
    send_frame({64'h00070035000C1234, 32'h11223344, 32'h0}, 12, 1'b1);
    idle(2);
    vectors++;
    if (pd_cnt != 1 || hv_cnt != 1 || mv_cnt != 0 || out_q.size() != 0) begin
      fails++;
      $display("FAIL filter_drop got pd=%0d hv=%0d mv=%0d out=%0d want 1 1 0 0",
               pd_cnt, hv_cnt, mv_cnt, out_q.size());
    end
    vectors++;
    if (dst_port !== 16'h0035 || stat_pkt_cnt !== 16'd5 || stat_err_cnt !== 16'd1) begin
      fails++;
      $display("FAIL filter_regs got dst=%h pkt=%h err=%h want 0035 0005 0001",
               dst_port, stat_pkt_cnt, stat_err_cnt);
    end
    clr();
    send_frame({64'h000712B700040000, 16'h5566, 48'h0}, 10, 1'b1);
    idle(2);
    vectors++;
    if (el_cnt != 1 || hv_cnt != 0 || pd_cnt != 0 || mv_cnt != 0) begin
      fails++;
      $display("FAIL len_short got el=%0d hv=%0d pd=%0d mv=%0d want 1 0 0 0",
               el_cnt, hv_cnt, pd_cnt, mv_cnt);
    end
    vectors++;
    if (stat_err_cnt !== 16'd2 || stat_pkt_cnt !== 16'd5) begin
      fails++; $display("FAIL len_short_cnt got err=%h pkt=%h want 0002 0005", stat_err_cnt, stat_pkt_cnt);
    end
  endtask

  task automatic test_len_edges();
    clr();
    send_frame({64'h000112B700080000, 64'h0}, 8, 1'b1);
    send_frame({64'h000212B700080000, 24'h010203, 40'h0}, 11, 1'b1);
    idle(2);
    vectors++;
    if (hv_cnt != 2 || el_cnt != 0 || mv_cnt != 0 || stat_pkt_cnt !== 16'd7) begin
      fails++;
      $display("FAIL zero_len got hv=%0d el=%0d mv=%0d pkt=%h want 2 0 0 0007",
               hv_cnt, el_cnt, mv_cnt, stat_pkt_cnt);
    end
    clr();
    send_frame({64'h000312B7000C0000, 64'h0}, 8, 1'b1);
    idle(2);
    vectors++;
    if (el_cnt != 1 || hv_cnt != 0 || stat_err_cnt !== 16'd3) begin
      fails++;
      $display("FAIL last_on_hdr got el=%0d hv=%0d err=%h want 1 0 0003", el_cnt, hv_cnt, stat_err_cnt);
    end
    clr();
    send_frame({64'h000412B7000C0000, 16'h7788, 48'h0}, 10, 1'b1);
    idle(2);
    vectors++;
    if (el_cnt != 1 || out_q.size() != 2 || out_q[1] !== 9'h188 || stat_err_cnt !== 16'd4) begin
      fails++;
      $display("FAIL early_last got el=%0d out=%p err=%h want 1 077 188 0004", el_cnt, out_q, stat_err_cnt);
    end
  endtask

  task automatic test_reset_mid();
    clr();
    send_frame({72'h04D212B7000CABCD11, 56'h0}, 9, 1'b0);
    s_data = 8'h22; s_valid = 1'b1;
    rstn = 1'b0;
    #2;
    vectors++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || stat_pkt_cnt !== 16'd0 ||
        stat_err_cnt !== 16'd0 || src_port !== 16'd0) begin
      fails++;
      $display("FAIL reset_mid got s_ready=%b m_valid=%b pkt=%h err=%h src=%h want 1 0 0 0 0",
               s_ready, m_valid, stat_pkt_cnt, stat_err_cnt, src_port);
    end
    s_valid = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    idle(1);
    test_basic(16'd1);
  endtask

  task automatic test_err_sat();
    clr();
    for (int i = 0; i < 65535; i++) put_byte(8'h00, 1'b1);
    idle(2);
    vectors++;
    if (stat_err_cnt !== 16'hFFFF || es_cnt != 65535) begin
      fails++; $display("FAIL err_reach got err=%h es=%0d want ffff 65535", stat_err_cnt, es_cnt);
    end
    put_byte(8'h00, 1'b1);
    idle(2);
    vectors++;
    if (stat_err_cnt !== 16'hFFFF || es_cnt != 65536) begin
      fails++; $display("FAIL err_sat got err=%h es=%0d want ffff 65536", stat_err_cnt, es_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic(16'd1);
    test_stall();
    test_pad();
    test_short();
    test_filter();
    test_len_edges();
    test_reset_mid();
    test_err_sat();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
